// File: rtl/neuron_update_engine.sv
// Time-multiplexed neuron state engine.
// Holds v, u, input accumulator, refractory count and model select for
// N_NEURONS neurons. Input events are accumulated while idle. A ts_start pulse
// starts a sweep that updates every neuron once, in index order. Spikes leave
// through a valid/ready event port.
// Handshake: a transfer happens on a rising edge where valid && ready are both 1.
// Once valid is raised, it and its payload stay stable until that edge.
// in_ready is high only in IDLE. spk_valid is held, with spk_id and spk_v
// unchanged, until spk_ready is seen.
module neuron_update_engine #(
   parameter int DATA_W    = 16,
   parameter int FRAC_W    = 8,
   parameter int N_NEURONS = 16,
   parameter int REFRAC_TS = 2,
   localparam int ID_W     = (N_NEURONS > 1) ? $clog2(N_NEURONS) : 1
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic                     cfg_we,
   input  logic [ID_W-1:0]          cfg_id,
   input  logic [1:0]               cfg_model,
   input  logic signed [DATA_W-1:0] u_init,
   input  logic signed [DATA_W-1:0] v_th,
   input  logic signed [DATA_W-1:0] a,
   input  logic signed [DATA_W-1:0] b,
   input  logic signed [DATA_W-1:0] c,
   input  logic signed [DATA_W-1:0] d,
   input  logic [3:0]               decay_sh,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [ID_W-1:0]          in_id,
   input  logic signed [DATA_W-1:0] in_weight,
   input  logic                     ts_start,
   output logic                     busy,
   output logic                     ts_done,
   output logic                     spk_valid,
   input  logic                     spk_ready,
   output logic [ID_W-1:0]          spk_id,
   output logic signed [DATA_W-1:0] spk_v
);

   localparam int REFR_W = (REFRAC_TS > 0) ? $clog2(REFRAC_TS + 1) : 1;
   localparam logic [ID_W-1:0] LAST_ID = ID_W'(N_NEURONS - 1);
   localparam logic [ID_W:0]   ID_LIMIT = (ID_W + 1)'(N_NEURONS);
   localparam logic signed [DATA_W+1:0] W_MAX = {3'b000, {(DATA_W-1){1'b1}}};
   localparam logic signed [DATA_W+1:0] W_MIN = {3'b111, {(DATA_W-1){1'b0}}};
   localparam logic signed [2*DATA_W-1:0] P_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
   localparam logic signed [2*DATA_W-1:0] P_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

   localparam logic [1:0] M_LIF  = 2'b00;
   localparam logic [1:0] M_IZH  = 2'b01;
   localparam logic [1:0] M_QLIF = 2'b10;
   localparam logic [1:0] M_OFF  = 2'b11;

   typedef enum logic [1:0] {IDLE, SWEEP, EMIT, DONE} state_t;
   state_t state;
   logic [ID_W-1:0] idx;

   logic signed [DATA_W-1:0] v_q   [N_NEURONS];
   logic signed [DATA_W-1:0] u_q   [N_NEURONS];
   logic signed [DATA_W-1:0] acc_q [N_NEURONS];
   logic [1:0]               model_q [N_NEURONS];
   logic [REFR_W-1:0]        refr_q  [N_NEURONS];

   // Sign-extend to the guard width used by every add/sub.
   function automatic logic signed [DATA_W+1:0] ext(input logic signed [DATA_W-1:0] x);
      return {{2{x[DATA_W-1]}}, x};
   endfunction

   // Clamp a guard-width result back into the signed DATA_W range.
   function automatic logic signed [DATA_W-1:0] sat(input logic signed [DATA_W+1:0] x);
      if (x > W_MAX)      return W_MAX[DATA_W-1:0];
      else if (x < W_MIN) return W_MIN[DATA_W-1:0];
      else                return x[DATA_W-1:0];
   endfunction

   // Fixed-point multiply: full product, arithmetic rescale, then clamp.
   function automatic logic signed [DATA_W-1:0] mul(input logic signed [DATA_W-1:0] x,
                                                     input logic signed [DATA_W-1:0] y);
      logic signed [2*DATA_W-1:0] p;
      p = x * y;
      p = p >>> FRAC_W;
      if (p > P_MAX)      return P_MAX[DATA_W-1:0];
      else if (p < P_MIN) return P_MIN[DATA_W-1:0];
      else                return p[DATA_W-1:0];
   endfunction

   assign in_ready = (state == IDLE);
   assign busy     = (state != IDLE);

   logic signed [DATA_W-1:0] cur_v, cur_u, cur_acc, leak, v_cand, v_next, u_next;
   logic [1:0]               cur_model;
   logic                     cur_refr, spike;
   logic                     in_ok, cfg_ok;

   assign in_ok  = ({1'b0, in_id}  < ID_LIMIT);
   assign cfg_ok = ({1'b0, cfg_id} < ID_LIMIT);

   // Candidate potential, spike decision and next v/u for the neuron at idx.
   always_comb begin
      cur_v     = v_q[idx];
      cur_u     = u_q[idx];
      cur_acc   = acc_q[idx];
      cur_model = model_q[idx];
      cur_refr  = (refr_q[idx] != '0);
      leak      = cur_v >>> decay_sh;
      v_cand    = cur_v;
      v_next    = cur_v;
      u_next    = cur_u;
      case (cur_model)
         M_LIF:   v_cand = sat(ext(cur_v) - ext(leak) + ext(cur_acc));
         M_IZH:   v_cand = sat(ext(cur_v) + ext(cur_acc) - ext(cur_u));
         M_QLIF:  v_cand = sat(ext(cur_v) - ext(leak) + ext(mul(cur_v, cur_v) >>> decay_sh)
                               + ext(cur_acc));
         default: v_cand = cur_v;
      endcase
      spike = !cur_refr && (cur_model != M_OFF) && (v_cand >= v_th);
      if (!cur_refr && cur_model != M_OFF) begin
         if (spike) begin
            if (cur_model == M_IZH) begin
               v_next = c;
               u_next = sat(ext(cur_u) + ext(d));
            end else begin
               v_next = sat(ext(v_cand) - ext(v_th));
            end
         end else begin
            v_next = v_cand;
            if (cur_model == M_IZH)
               u_next = sat(ext(cur_u) + ext(mul(a, sat(ext(mul(b, cur_v)) - ext(cur_u)))));
         end
      end
   end

   // Control FSM plus all neuron state; config and events land only in IDLE.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         idx       <= '0;
         ts_done   <= 1'b0;
         spk_valid <= 1'b0;
         spk_id    <= '0;
         spk_v     <= '0;
         for (int i = 0; i < N_NEURONS; i++) begin
            v_q[i]     <= '0;
            u_q[i]     <= '0;
            acc_q[i]   <= '0;
            model_q[i] <= M_LIF;
            refr_q[i]  <= '0;
         end
      end else begin
         ts_done <= 1'b0;
         case (state)
            IDLE: begin
               if (in_valid && in_ok)
                  acc_q[in_id] <= sat(ext(acc_q[in_id]) + ext(in_weight));
               // Config is written after the event so a same-id collision drops the weight.
               if (cfg_we && cfg_ok) begin
                  model_q[cfg_id] <= cfg_model;
                  v_q[cfg_id]     <= '0;
                  u_q[cfg_id]     <= u_init;
                  acc_q[cfg_id]   <= '0;
                  refr_q[cfg_id]  <= '0;
               end
               if (ts_start) begin
                  state <= SWEEP;
                  idx   <= '0;
               end
            end
            SWEEP: begin
               v_q[idx]   <= v_next;
               u_q[idx]   <= u_next;
               acc_q[idx] <= '0;
               if (cur_refr)
                  refr_q[idx] <= refr_q[idx] - REFR_W'(1);
               else if (spike)
                  refr_q[idx] <= REFR_W'(REFRAC_TS);
               if (spike) begin
                  spk_valid <= 1'b1;
                  spk_id    <= idx;
                  spk_v     <= v_cand;
                  state     <= EMIT;
               end else if (idx == LAST_ID) begin
                  state   <= DONE;
                  ts_done <= 1'b1;
               end else begin
                  idx <= idx + 1'b1;
               end
            end
            EMIT: begin
               if (spk_ready) begin
                  spk_valid <= 1'b0;
                  if (idx == LAST_ID) begin
                     state   <= DONE;
                     ts_done <= 1'b1;
                  end else begin
                     idx   <= idx + 1'b1;
                     state <= SWEEP;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_neuron_update_engine.sv
// Directed bench for neuron_update_engine (Q8.8, 16 neurons, 2-step refractory).
`timescale 1ns/1ps
module tb_neuron_update_engine;

   localparam int DATA_W = 16;
   localparam int ID_W   = 4;

   logic              clk = 1'b0;
   logic              rst;
   logic              cfg_we;
   logic [ID_W-1:0]   cfg_id;
   logic [1:0]        cfg_model;
   logic [DATA_W-1:0] u_init, v_th, a, b, c, d;
   logic [3:0]        decay_sh;
   logic              in_valid, in_ready;
   logic [ID_W-1:0]   in_id;
   logic [DATA_W-1:0] in_weight;
   logic              ts_start, busy, ts_done;
   logic              spk_valid, spk_ready;
   logic [ID_W-1:0]   spk_id;
   logic [DATA_W-1:0] spk_v;

   int checks = 0;
   int errors = 0;
   int done_cnt = 0;
   int rd = 0;
   logic [ID_W+DATA_W-1:0] exp_q[$];
   logic [ID_W+DATA_W-1:0] got_q[$];

   // clock / reset
   always #5 clk = ~clk;

   neuron_update_engine dut (
      .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_id(cfg_id), .cfg_model(cfg_model),
      .u_init(u_init), .v_th(v_th), .a(a), .b(b), .c(c), .d(d), .decay_sh(decay_sh),
      .in_valid(in_valid), .in_ready(in_ready), .in_id(in_id), .in_weight(in_weight),
      .ts_start(ts_start), .busy(busy), .ts_done(ts_done), .spk_valid(spk_valid),
      .spk_ready(spk_ready), .spk_id(spk_id), .spk_v(spk_v)
   );

   // Monitor: inputs change 1ns after posedge, so at negedge both sides are stable.
   always @(negedge clk) begin
      if (!rst) begin
         if (ts_done) done_cnt++;
         if (spk_valid && spk_ready) got_q.push_back({spk_id, spk_v});
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   function automatic logic [DATA_W-1:0] v_of(input int i);
      return dut.v_q[i];
   endfunction
   function automatic logic [DATA_W-1:0] u_of(input int i);
      return dut.u_q[i];
   endfunction
   function automatic logic [DATA_W-1:0] acc_of(input int i);
      return dut.acc_q[i];
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic send(input logic [ID_W-1:0] id, input logic [DATA_W-1:0] w);
      in_valid  = 1'b1;
      in_id     = id;
      in_weight = w;
      step();
      in_valid  = 1'b0;
   endtask

   task automatic cfg(input logic [ID_W-1:0] id, input logic [1:0] m, input logic [DATA_W-1:0] ui);
      cfg_we    = 1'b1;
      cfg_id    = id;
      cfg_model = m;
      u_init    = ui;
      step();
      cfg_we    = 1'b0;
   endtask

   // Wait for ts_done with a cycle budget; n counts edges since the ts_start edge.
   task automatic wait_done(inout int n);
      while (!ts_done && n < 400) begin
         step();
         n++;
      end
      check("ts_done_seen", 32'(ts_done), 32'd1);
      step();
   endtask

   task automatic run_ts(output int n);
      ts_start = 1'b1;
      step();
      ts_start = 1'b0;
      n = 1;
      wait_done(n);
   endtask

   // Scoreboard: every expected spike must appear in order, with nothing extra.
   task automatic expect_spikes(input string tag);
      logic [ID_W+DATA_W-1:0] e;
      while (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         if (rd < got_q.size()) begin
            check({tag, "_spike"}, 32'(got_q[rd]), 32'(e));
            rd++;
         end else begin
            check({tag, "_spike_missing"}, 32'hFFFF_FFFF, 32'(e));
         end
      end
      check({tag, "_extra_spikes"}, 32'(got_q.size() - rd), 32'd0);
      rd = got_q.size();
   endtask

   initial begin
      int n;
      int d0;
      rst = 1'b1; cfg_we = 0; cfg_id = 0; cfg_model = 0; u_init = 0;
      v_th = 16'h0100; a = 0; b = 0; c = 0; d = 0; decay_sh = 4'd15;
      in_valid = 0; in_id = 0; in_weight = 0; ts_start = 0; spk_ready = 1'b1;
      do_reset();

      // Reset state
      check("rst_busy", 32'(busy), 0);
      check("rst_in_ready", 32'(in_ready), 1);
      check("rst_ts_done", 32'(ts_done), 0);
      check("rst_spk_valid", 32'(spk_valid), 0);
      check("rst_spk_id", 32'(spk_id), 0);
      check("rst_spk_v", 32'(spk_v), 0);

      // 1 LIF: 0.6 + 0.6 on id3 crosses 1.0, leaves 0.2
      send(4'd3, 16'h0099);
      send(4'd3, 16'h0099);
      check("lif_acc", 32'(acc_of(3)), 32'h0132);
      d0 = done_cnt;
      run_ts(n);
      check("lif_latency", 32'(n), 32'd18);
      exp_q.push_back({4'd3, 16'h0132});
      expect_spikes("lif");
      check("lif_v3", 32'(v_of(3)), 32'h0032);
      check("lif_acc_clr", 32'(acc_of(3)), 0);
      check("lif_done_once", 32'(done_cnt - d0), 1);

      // 2 Backpressure on id0 then id5
      do_reset();
      spk_ready = 1'b0;
      send(4'd0, 16'h0200);
      send(4'd5, 16'h0200);
      d0 = done_cnt;
      ts_start = 1'b1;
      step();
      ts_start = 1'b0;
      step();
      check("bp_valid", 32'(spk_valid), 1);
      check("bp_id", 32'(spk_id), 0);
      check("bp_v", 32'(spk_v), 32'h0200);
      for (int i = 0; i < 4; i++) begin
         step();
         check("bp_hold_valid", 32'(spk_valid), 1);
         check("bp_hold_id", 32'(spk_id), 0);
      end
      check("bp_no_xfer", 32'(got_q.size() - rd), 0);
      spk_ready = 1'b1;
      n = 6;
      wait_done(n);
      exp_q.push_back({4'd0, 16'h0200});
      exp_q.push_back({4'd5, 16'h0200});
      expect_spikes("bp");
      step();
      check("bp_done_once", 32'(done_cnt - d0), 1);
      check("bp_idle", 32'(busy), 0);

      // 3 Saturation of the accumulator
      do_reset();
      send(4'd1, 16'h7000);
      check("sat_acc1", 32'(acc_of(1)), 32'h7000);
      send(4'd1, 16'h7000);
      send(4'd1, 16'h7000);
      check("sat_pos", 32'(acc_of(1)), 32'h7FFF);
      send(4'd2, 16'h9000);
      send(4'd2, 16'h9000);
      check("sat_neg", 32'(acc_of(2)), 32'h8000);

      // 4 Izhikevich spike, reset to c, u += d, then refractory
      do_reset();
      c = 16'hFFC0; d = 16'h0080; a = 0; b = 0;
      cfg(4'd4, 2'b01, 16'h0080);
      check("izh_u_init", 32'(u_of(4)), 32'h0080);
      send(4'd4, 16'h0200);
      run_ts(n);
      exp_q.push_back({4'd4, 16'h0180});
      expect_spikes("izh");
      check("izh_v_c", 32'(v_of(4)), 32'hFFC0);
      check("izh_u_d", 32'(u_of(4)), 32'h0100);
      send(4'd4, 16'h0400);
      run_ts(n);
      check("izh_nospike_latency", 32'(n), 32'd17);
      expect_spikes("izh_refr");
      check("izh_refr_v", 32'(v_of(4)), 32'hFFC0);
      check("izh_refr_acc", 32'(acc_of(4)), 0);
      run_ts(n);
      // refractory over: a=0.5, b=0.25 -> v=-1.25, u=1.0-0.53125
      a = 16'h0080; b = 16'h0040;
      run_ts(n);
      expect_spikes("izh_sub");
      check("izh_sub_v", 32'(v_of(4)), 32'hFEC0);
      check("izh_sub_u", 32'(u_of(4)), 32'h0078);

      // 5 Collisions: event with ts_start counts; ts_start/in_valid while busy ignored
      do_reset();
      a = 0; b = 0; c = 0; d = 0;
      send(4'd6, 16'h0180);
      d0 = done_cnt;
      in_valid = 1'b1; in_id = 4'd2; in_weight = 16'h0100; ts_start = 1'b1;
      step();
      in_valid = 1'b0; ts_start = 1'b0;
      step();
      ts_start = 1'b1; in_valid = 1'b1; in_id = 4'd9; in_weight = 16'h0400;
      check("col_busy", 32'(busy), 1);
      check("col_in_ready", 32'(in_ready), 0);
      step();
      ts_start = 1'b0; in_valid = 1'b0;
      n = 3;
      wait_done(n);
      exp_q.push_back({4'd2, 16'h0100});
      exp_q.push_back({4'd6, 16'h0180});
      expect_spikes("col");
      check("col_v6", 32'(v_of(6)), 32'h0080);
      step();
      step();
      check("col_done_once", 32'(done_cnt - d0), 1);
      check("col_idle", 32'(busy), 0);

      // 5b reset while holding a spike
      send(4'd9, 16'h0200);
      spk_ready = 1'b0;
      d0 = done_cnt;
      ts_start = 1'b1;
      step();
      ts_start = 1'b0;
      n = 0;
      while (!spk_valid && n < 40) begin
         step();
         n++;
      end
      check("emit_id", 32'(spk_id), 32'd9);
      rst = 1'b1;
      step();
      check("emit_rst_valid", 32'(spk_valid), 0);
      check("emit_rst_busy", 32'(busy), 0);
      check("emit_rst_spk_id", 32'(spk_id), 0);
      check("emit_rst_v6", 32'(v_of(6)), 0);
      rst = 1'b0;
      spk_ready = 1'b1;
      step();
      step();
      check("emit_rst_no_done", 32'(done_cnt - d0), 0);
      rd = got_q.size();

      // 6 Disabled model and config/event collision
      do_reset();
      cfg(4'd7, 2'b11, 16'h0010);
      send(4'd7, 16'h7000);
      check("off_acc_in", 32'(acc_of(7)), 32'h7000);
      send(4'd8, 16'h0100);
      cfg_we = 1'b1; cfg_id = 4'd8; cfg_model = 2'b00; u_init = 0;
      in_valid = 1'b1; in_id = 4'd8; in_weight = 16'h0300;
      step();
      cfg_we = 1'b0; in_valid = 1'b0;
      check("cfg_wins", 32'(acc_of(8)), 0);
      run_ts(n);
      expect_spikes("off");
      check("off_v7", 32'(v_of(7)), 0);
      check("off_u7", 32'(u_of(7)), 32'h0010);
      check("off_acc_clr", 32'(acc_of(7)), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
